alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue_if.sv | 28 ++
 rtl/alu_issue.sv | 189 ++++++++++++++++++
 tb/tb_alu_issue.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// Handshake bundle between the decode front end and the ALU issue stage.
// The slave modport belongs to alu_issue. The master modport belongs to whatever drives it.
interface alu_issue_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic [31:0] in_rs1_data;
   logic [31:0] in_rs2_data;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_op;
   logic [31:0] out_operand1;
   logic [31:0] out_operand2;
   logic [4:0]  out_rd;
   logic        out_we;
   logic        out_illegal;

   modport slave (
      input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
      output in_ready, out_valid, out_op, out_operand1, out_operand2, out_rd, out_we, out_illegal
   );

   modport master (
      output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
      input  in_ready, out_valid, out_op, out_operand1, out_operand2, out_rd, out_we, out_illegal
   );
endinterface

// File: rtl/alu_issue.sv
// RV32I integer decode and ALU issue stage. It holds a main/skid buffer pair.
// Entries are decoded on accept. The main entry drives the registered outputs directly.
module alu_issue #(
   parameter logic [3:0] ILLEGAL_OP = 4'b0000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   alu_issue_if.slave bus
);

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000, OP_SUB = 4'b0001, OP_XOR = 4'b0010, OP_OR  = 4'b0011,
      OP_AND  = 4'b0100, OP_SLT = 4'b0101, OP_SLL = 4'b0110, OP_SRL = 4'b0111,
      OP_SRA  = 4'b1000, OP_SLTU = 4'b1001
   } alu_op_e;

   typedef enum logic [6:0] {
      OPC_OP     = 7'b0110011, OPC_IMM   = 7'b0010011, OPC_LUI    = 7'b0110111,
      OPC_AUIPC  = 7'b0010111, OPC_LOAD  = 7'b0000011, OPC_STORE  = 7'b0100011,
      OPC_BRANCH = 7'b1100011
   } opcode_e;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [4:0]  rd;
      logic        we;
      logic        illegal;
   } entry_t;

   entry_t main_q, skid_q, dec;
   logic   main_valid, skid_valid;
   logic   accept, issue;

   // The base operation shared by the R-type and I-type encodings when funct7 is zero.
   function automatic logic [3:0] base_op(input logic [2:0] f3);
      case (f3)
         3'd0:    base_op = OP_ADD;
         3'd1:    base_op = OP_SLL;
         3'd2:    base_op = OP_SLT;
         3'd3:    base_op = OP_SLTU;
         3'd4:    base_op = OP_XOR;
         3'd5:    base_op = OP_SRL;
         3'd6:    base_op = OP_OR;
         default: base_op = OP_AND;
      endcase
   endfunction

   logic [6:0]  opcode, f7;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_u;
   logic        dec_we, dec_ill;

   assign opcode = bus.in_instr[6:0];
   assign f3     = bus.in_instr[14:12];
   assign f7     = bus.in_instr[31:25];
   assign imm_i  = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
   assign imm_s  = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
   assign imm_u  = {bus.in_instr[31:12], 12'b0};

   always_comb begin
      // NOTE: every field gets a default before the case. Without it, synthesis infers latches.
      dec     = '0;
      dec_we  = 1'b0;
      dec_ill = 1'b0;
      case (opcode)
         OPC_OP: begin
            dec.op1 = bus.in_rs1_data;
            dec.op2 = bus.in_rs2_data;
            dec_we  = 1'b1;
            if (f7 == 7'b0000000)
               dec.op = base_op(f3);
            else if (f7 == 7'b0100000 && f3 == 3'd0)
               dec.op = OP_SUB;
            else if (f7 == 7'b0100000 && f3 == 3'd5)
               dec.op = OP_SRA;
            else
               dec_ill = 1'b1;
         end
         OPC_IMM: begin
            dec.op1 = bus.in_rs1_data;
            dec_we  = 1'b1;
            if (f3 == 3'd1 || f3 == 3'd5) begin
               dec.op2 = {27'b0, bus.in_instr[24:20]};
               if (f7 == 7'b0000000)
                  dec.op = base_op(f3);
               else if (f7 == 7'b0100000 && f3 == 3'd5)
                  dec.op = OP_SRA;
               else
                  dec_ill = 1'b1;
            end else begin
               dec.op  = base_op(f3);
               dec.op2 = imm_i;
            end
         end
         OPC_LUI: begin
            dec.op  = OP_ADD;
            dec.op2 = imm_u;
            dec_we  = 1'b1;
         end
         OPC_AUIPC: begin
            dec.op  = OP_ADD;
            dec.op1 = bus.in_pc;
            dec.op2 = imm_u;
            dec_we  = 1'b1;
         end
         OPC_LOAD: begin
            dec.op  = OP_ADD;
            dec.op1 = bus.in_rs1_data;
            dec.op2 = imm_i;
            dec_we  = 1'b1;
            dec_ill = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
         end
         OPC_STORE: begin
            dec.op  = OP_ADD;
            dec.op1 = bus.in_rs1_data;
            dec.op2 = imm_s;
            dec_ill = (f3 > 3'd2);
         end
         OPC_BRANCH: begin
            dec.op1 = bus.in_rs1_data;
            dec.op2 = bus.in_rs2_data;
            case (f3)
               3'd0, 3'd1: dec.op = OP_SUB;
               3'd4, 3'd5: dec.op = OP_SLT;
               3'd6, 3'd7: dec.op = OP_SLTU;
               default:    dec_ill = 1'b1;
            endcase
         end
         default: dec_ill = 1'b1;
      endcase

      // A write to x0 is discarded, so the entry carries no destination at all.
      if (dec_ill) begin
         dec         = '0;
         dec.op      = ILLEGAL_OP;
         dec.illegal = 1'b1;
      end else if (dec_we && bus.in_instr[11:7] != 5'd0) begin
         dec.rd = bus.in_instr[11:7];
         dec.we = 1'b1;
      end
   end

   assign accept = bus.in_valid && bus.in_ready && !flush;
   assign issue  = main_valid && bus.out_ready;

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the payload registers are reset too, because they drive the outputs directly and must read as zero in reset.
      if (rst) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_q     <= '0;
         skid_q     <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (issue) begin
         // While skid is full, in_ready is low, so an issue cycle never carries an accept as well.
         if (skid_valid) begin
            main_q     <= skid_q;
            skid_valid <= 1'b0;
         end else if (accept) begin
            main_q     <= dec;
         end else begin
            main_valid <= 1'b0;
         end
      end else if (accept) begin
         if (main_valid) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
         end else begin
            main_q     <= dec;
            main_valid <= 1'b1;
         end
      end
   end

   assign bus.in_ready     = !skid_valid;
   assign bus.out_valid    = main_valid;
   assign bus.out_op       = main_q.op;
   assign bus.out_operand1 = main_q.op1;
   assign bus.out_operand2 = main_q.op2;
   assign bus.out_rd       = main_q.rd;
   assign bus.out_we       = main_q.we;
   assign bus.out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed and randomized bench for alu_issue. A queue of at most two decoded entries
// stands in for the buffer, and the RV32I decode rules are evaluated independently.
module tb_alu_issue;
   localparam logic [3:0] ILLEGAL = 4'b1111;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] o1;
      logic [31:0] o2;
      logic [4:0]  rd;
      logic        we;
      logic        ill;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   int   n_assert = 0;
   int   n_fail = 0;
   exp_t q[$];

   alu_issue_if bus ();

   alu_issue #(.ILLEGAL_OP(ILLEGAL)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Decode straight from the instruction-set tables.
   function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] a, input logic [31:0] b);
      logic [3:0] rtab [8];
      exp_t       e;
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      logic [31:0] imm_i, imm_s, imm_u;
      rtab  = '{4'd0, 4'd6, 4'd5, 4'd9, 4'd2, 4'd7, 4'd3, 4'd4};
      opc   = ins[6:0];
      f3    = ins[14:12];
      f7    = ins[31:25];
      imm_i = 32'(signed'(ins[31:20]));
      imm_s = 32'(signed'({ins[31:25], ins[11:7]}));
      imm_u = ins & 32'hFFFF_F000;
      e = '{op: 4'd0, o1: 32'd0, o2: 32'd0, rd: 5'd0, we: 1'b0, ill: 1'b0};
      case (opc)
         7'h33: begin
            e.o1 = a; e.o2 = b; e.we = 1'b1;
            if (f7 == 7'h00) e.op = rtab[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) e.op = 4'd1;
            else if (f7 == 7'h20 && f3 == 3'd5) e.op = 4'd8;
            else e.ill = 1'b1;
         end
         7'h13: begin
            e.o1 = a; e.we = 1'b1;
            if (f3 == 3'd1 || f3 == 3'd5) begin
               e.o2 = 32'(ins[24:20]);
               if (f7 == 7'h00) e.op = rtab[f3];
               else if (f7 == 7'h20 && f3 == 3'd5) e.op = 4'd8;
               else e.ill = 1'b1;
            end else begin
               e.op = rtab[f3]; e.o2 = imm_i;
            end
         end
         7'h37: begin e.o2 = imm_u; e.we = 1'b1; end
         7'h17: begin e.o1 = pc; e.o2 = imm_u; e.we = 1'b1; end
         7'h03: begin e.o1 = a; e.o2 = imm_i; e.we = 1'b1; e.ill = (f3 == 3'd3 || f3 > 3'd5); end
         7'h23: begin e.o1 = a; e.o2 = imm_s; e.ill = (f3 > 3'd2); end
         7'h63: begin
            e.o1 = a; e.o2 = b;
            if (f3 < 3'd2) e.op = 4'd1;
            else if (f3 == 3'd4 || f3 == 3'd5) e.op = 4'd5;
            else if (f3 >= 3'd6) e.op = 4'd9;
            else e.ill = 1'b1;
         end
         default: e.ill = 1'b1;
      endcase
      if (e.ill) e = '{op: ILLEGAL, o1: 32'd0, o2: 32'd0, rd: 5'd0, we: 1'b0, ill: 1'b1};
      else if (e.we && ins[11:7] != 5'd0) e.rd = ins[11:7];
      else e.we = 1'b0;
      return e;
   endfunction

   task automatic check_model(input string tag);
      check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(q.size() > 0));
      check({tag, ".in_ready"},  32'(bus.in_ready),  32'(q.size() < 2));
      if (q.size() > 0) begin
         check({tag, ".op"},  32'(bus.out_op),       32'(q[0].op));
         check({tag, ".op1"}, bus.out_operand1,      q[0].o1);
         check({tag, ".op2"}, bus.out_operand2,      q[0].o2);
         check({tag, ".rd"},  32'(bus.out_rd),       32'(q[0].rd));
         check({tag, ".we"},  32'(bus.out_we),       32'(q[0].we));
         check({tag, ".ill"}, 32'(bus.out_illegal),  32'(q[0].ill));
      end
   endtask

   // One clock cycle. It drives the inputs, advances the model, and checks the outputs #1 after the edge.
   task automatic step(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b, input logic rdy, input logic fl);
      bit acc, iss;
      bus.in_valid = v; bus.in_instr = ins; bus.in_pc = pc;
      bus.in_rs1_data = a; bus.in_rs2_data = b; bus.out_ready = rdy; flush = fl;
      acc = v && q.size() < 2;
      iss = rdy && q.size() > 0;
      if (fl) q.delete();
      else begin
         if (iss) void'(q.pop_front());
         if (acc) q.push_back(ref_decode(ins, pc, a, b));
      end
      @(posedge clk);
      #1;
      check_model(tag);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, ".out_valid"}, 32'(bus.out_valid),   32'd0);
      check({tag, ".in_ready"},  32'(bus.in_ready),    32'd1);
      check({tag, ".op"},        32'(bus.out_op),      32'd0);
      check({tag, ".op1"},       bus.out_operand1,     32'd0);
      check({tag, ".op2"},       bus.out_operand2,     32'd0);
      check({tag, ".rd"},        32'(bus.out_rd),      32'd0);
      check({tag, ".we"},        32'(bus.out_we),      32'd0);
      check({tag, ".ill"},       32'(bus.out_illegal), 32'd0);
   endtask

   function automatic logic [31:0] gen_instr();
      logic [6:0] opcs [8];
      logic [31:0] ins;
      int k;
      opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h33};
      ins = $urandom;
      k = $urandom_range(0, 9);
      if (k < 8) begin
         ins[6:0] = opcs[k];
         if (opcs[k] == 7'h33 || opcs[k] == 7'h13)
            case ($urandom_range(0, 3))
               0, 1:    ins[31:25] = 7'h00;
               2:       ins[31:25] = 7'h20;
               default: ;
            endcase
      end
      return ins;
   endfunction

   initial begin
      bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
      bus.in_rs1_data = '0; bus.in_rs2_data = '0; bus.out_ready = 1'b0;

      #12;
      check_cleared("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_model("idle");

      step("add", 1'b1, 32'h002081B3, 32'h100, 32'd5, 32'd7, 1'b1, 1'b0);
      check("add.op", 32'(bus.out_op), 32'd0);
      check("add.op1", bus.out_operand1, 32'd5);
      check("add.op2", bus.out_operand2, 32'd7);
      check("add.rd", 32'(bus.out_rd), 32'd3);
      check("add.we", 32'(bus.out_we), 32'd1);

      step("srai", 1'b1, 32'h40435293, 32'h104, 32'h80000000, 32'd0, 1'b1, 1'b0);
      check("srai.op", 32'(bus.out_op), 32'd8);
      check("srai.op2", bus.out_operand2, 32'd4);
      check("srai.rd", 32'(bus.out_rd), 32'd5);

      step("blt", 1'b1, 32'h0020C063, 32'h108, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0);
      check("blt.op", 32'(bus.out_op), 32'd5);
      check("blt.we", 32'(bus.out_we), 32'd0);
      check("blt.rd", 32'(bus.out_rd), 32'd0);

      step("illegal", 1'b1, 32'hFFFFFFFF, 32'h10C, 32'd9, 32'd9, 1'b1, 1'b0);
      check("illegal.op", 32'(bus.out_op), 32'(ILLEGAL));
      check("illegal.ill", 32'(bus.out_illegal), 32'd1);
      check("illegal.we", 32'(bus.out_we), 32'd0);
      check("illegal.op1", bus.out_operand1, 32'd0);
      check("illegal.op2", bus.out_operand2, 32'd0);

      // Back-pressure. Of three offers, only the first two fit. The third one is never taken.
      step("drain", 1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
      step("bp1", 1'b1, 32'h00100093, 32'h200, 32'd10, 32'd0, 1'b0, 1'b0);
      step("bp2", 1'b1, 32'h00200113, 32'h204, 32'd10, 32'd0, 1'b0, 1'b0);
      check("bp2.in_ready", 32'(bus.in_ready), 32'd0);
      step("bp3", 1'b1, 32'h00300193, 32'h208, 32'd10, 32'd0, 1'b0, 1'b0);
      check("bp3.op2_held", bus.out_operand2, 32'd1);
      step("bp_issue1", 1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
      check("bp_issue1.op2", bus.out_operand2, 32'd2);
      check("bp_issue1.in_ready", 32'(bus.in_ready), 32'd1);
      step("bp_issue2", 1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
      check("bp_issue2.out_valid", 32'(bus.out_valid), 32'd0);

      // Flush with both entries full and a new entry offered.
      step("fl_fill1", 1'b1, 32'h00100093, 32'h300, 32'd1, 32'd0, 1'b0, 1'b0);
      step("fl_fill2", 1'b1, 32'h00200113, 32'h304, 32'd1, 32'd0, 1'b0, 1'b0);
      step("flush", 1'b1, 32'h00300193, 32'h308, 32'd1, 32'd0, 1'b1, 1'b1);
      check("flush.out_valid", 32'(bus.out_valid), 32'd0);
      check("flush.in_ready", 32'(bus.in_ready), 32'd1);
      step("flush_after", 1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
      check("flush_after.out_valid", 32'(bus.out_valid), 32'd0);

      // Reset pulsed between edges while both entries are held.
      step("rs_fill1", 1'b1, 32'h00500293, 32'h400, 32'd3, 32'd0, 1'b0, 1'b0);
      step("rs_fill2", 1'b1, 32'h00600313, 32'h404, 32'd3, 32'd0, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1 check_cleared("async_rst");
      #1 rst = 1'b0;
      q.delete();
      step("rs_after", 1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
      step("rs_after2", 1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);

      for (int i = 0; i < 400; i++)
         step("rand", ($urandom_range(0, 9) < 7), gen_instr(), $urandom, $urandom, $urandom,
              ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
